// File: rtl/tie_mon_pkg.sv
// rtl/tie_mon_pkg.sv - shared state encoding and widths for the tie-cell level monitor
package tie_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_MON   = 2'd2,
      ST_FAULT = 2'd3
   } tie_mon_state_e;

   localparam int ERRCNT_W = 8;

endpackage

// File: rtl/tie_mon_sync.sv
// rtl/tie_mon_sync.sv - N-stage synchronizer with a configurable reset value
module tie_mon_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= {STAGES{RST_VAL}};
      end else begin
         sr <= {sr[STAGES-2:0], d};
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/tie_level_monitor.sv
// rtl/tie_level_monitor.sv - sticky fault checker for tie-high/tie-low cell outputs
// Define TIE_MON_ERRCNT_EN to build the saturating fault-event counter behind ERRCNT.
module tie_level_monitor
   import tie_mon_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ARM_CYCLES  = 3,
   parameter int FAULT_CNT   = 4,
   parameter int CNT_W       = 8
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                EN,
   input  logic                CLR,
   input  logic                TH,
   input  logic                TL,
   output logic                FAULT_H,
   output logic                FAULT_L,
   output logic                FAULT,
   output logic                ACTIVE,
   output logic [ERRCNT_W-1:0] ERRCNT
);

   localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_CYCLES - 1);
   localparam logic [CNT_W-1:0] FAULT_LIM = CNT_W'(FAULT_CNT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic s_th;
   logic s_tl;
   logic m_h;
   logic m_l;

   tie_mon_state_e   state,   state_n;
   logic [CNT_W-1:0] arm_cnt, arm_n;
   logic [CNT_W-1:0] cnt_h,   cnt_h_n;
   logic [CNT_W-1:0] cnt_l,   cnt_l_n;
   logic             fault_h_n;
   logic             fault_l_n;

   // Reset values match the expected levels so the first samples after reset are clean.
   tie_mon_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_th (
      .clk (CLK),
      .rst (RST),
      .d   (TH),
      .q   (s_th)
   );

   tie_mon_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tl (
      .clk (CLK),
      .rst (RST),
      .d   (TL),
      .q   (s_tl)
   );

   assign m_h = ~s_th;
   assign m_l = s_tl;

   always_comb begin
      state_n   = state;
      arm_n     = arm_cnt;
      cnt_h_n   = cnt_h;
      cnt_l_n   = cnt_l;
      fault_h_n = FAULT_H;
      fault_l_n = FAULT_L;

      if (!EN) begin
         state_n = ST_IDLE;
         arm_n   = '0;
         cnt_h_n = '0;
         cnt_l_n = '0;
         if (CLR) begin
            fault_h_n = 1'b0;
            fault_l_n = 1'b0;
         end
      end else if (CLR) begin
         // Clearing wins over any fault that would have been declared on this edge.
         state_n   = ST_ARM;
         arm_n     = '0;
         cnt_h_n   = '0;
         cnt_l_n   = '0;
         fault_h_n = 1'b0;
         fault_l_n = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_n = ST_ARM;
               arm_n   = '0;
               cnt_h_n = '0;
               cnt_l_n = '0;
            end
            ST_ARM: begin
               if (arm_cnt >= ARM_LAST) begin
                  state_n = ST_MON;
                  arm_n   = '0;
               end else begin
                  arm_n = arm_cnt + CNT_ONE;
               end
            end
            ST_MON: begin
               if (m_h) begin
                  cnt_h_n = (cnt_h >= FAULT_LIM) ? FAULT_LIM : cnt_h + CNT_ONE;
               end else begin
                  cnt_h_n = '0;
               end
               if (m_l) begin
                  cnt_l_n = (cnt_l >= FAULT_LIM) ? FAULT_LIM : cnt_l + CNT_ONE;
               end else begin
                  cnt_l_n = '0;
               end
               if (m_h && (cnt_h_n == FAULT_LIM)) begin
                  fault_h_n = 1'b1;
                  state_n   = ST_FAULT;
               end
               if (m_l && (cnt_l_n == FAULT_LIM)) begin
                  fault_l_n = 1'b1;
                  state_n   = ST_FAULT;
               end
            end
            default: begin
               state_n = ST_FAULT;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         arm_cnt <= '0;
         cnt_h   <= '0;
         cnt_l   <= '0;
         FAULT_H <= 1'b0;
         FAULT_L <= 1'b0;
         FAULT   <= 1'b0;
         ACTIVE  <= 1'b0;
      end else begin
         state   <= state_n;
         arm_cnt <= arm_n;
         cnt_h   <= cnt_h_n;
         cnt_l   <= cnt_l_n;
         FAULT_H <= fault_h_n;
         FAULT_L <= fault_l_n;
         FAULT   <= fault_h_n | fault_l_n;
         ACTIVE  <= (state_n == ST_MON);
      end
   end

`ifdef TIE_MON_ERRCNT_EN
   logic enter_fault;
   logic [ERRCNT_W-1:0] errcnt_q;

   assign enter_fault = (state_n == ST_FAULT) && (state != ST_FAULT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         errcnt_q <= '0;
      end else if (enter_fault && (errcnt_q != {ERRCNT_W{1'b1}})) begin
         errcnt_q <= errcnt_q + ERRCNT_W'(1);
      end
   end

   assign ERRCNT = errcnt_q;
`else
   assign ERRCNT = '0;
`endif

endmodule
